serial_mag_comparator: RTL
==========================

Name: serial_mag_comparator

Overview:
- Parametrised, bit-serial magnitude comparator; the sequential successor to the team's 4-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, one bit per clock, under a start/done handshake.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Used where area matters more than latency, e.g. threshold checks in control paths.

Parameters:
- WIDTH, 8, operand width in bits; legal range WIDTH >= 2.
- IDX_W, $clog2(WIDTH), width of the internal bit-index counter (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronised externally.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare; captured with start.
- A  input  WIDTH  operand A; captured with start.
- B  input  WIDTH  operand B; captured with start.
- busy  output  1  high while in BUSY state.
- done  output  1  one-cycle pulse when the result is valid.
- G  output  1  A > B.
- L  output  1  A < B.
- E  output  1  A == B.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM -> IDLE.
  - busy, done, G, L, E = 0.
  - Capture registers and index = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE/DONE + start=1:
  - Capture A, B and signed_mode.
  - index <= WIDTH-1; decided flag <= 0.
  - G/L/E <= 0; next state BUSY.
- DONE + start=0: next state IDLE. DONE always lasts exactly one cycle.
- BUSY, one bit per cycle at position index:
  - If decided=0 and A[index] != B[index], set decided=1 and latch the result:
    - Unsigned, or signed with index < WIDTH-1: A bit = 1 -> G; else L.
    - Signed with index == WIDTH-1 (sign bit): A bit = 1 -> L; else G.
  - Once decided=1, later bits never alter the result.
  - If index == 0 (or the early-exit condition holds): go to DONE and drive G/L/E. If decided=0, E=1.
  - Otherwise index decrements.
- Latency (base build):
  - Start sampled at edge 0; BUSY covers edges 1..WIDTH.
  - done=1 and the result are valid in the cycle after edge WIDTH.
- Result outputs:
  - Exactly one of G/L/E is high after each completion.
  - They hold until the next accepted start, which clears them.
- busy=1 exactly while in BUSY; done=1 exactly while in DONE.
- start during BUSY is ignored. Changes on A, B or signed_mode during BUSY have no effect.
- Back-to-back: start asserted in the DONE cycle is accepted; the next BUSY begins immediately with no IDLE cycle.
- Reset mid-operation aborts immediately: all outputs 0, no done pulse.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: BUSY leaves to DONE in the same cycle the first differing bit is found.
  - Latency varies from 1 to WIDTH BUSY cycles.
  - Equal operands still take WIDTH cycles.
- Undefined: fixed WIDTH-cycle latency for every operation (constant-time behaviour).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> busy=done=G=L=E=0; start withheld -> outputs stay 0.
- WIDTH=8, signed_mode=0, A=8'hA5, B=8'h5A, start pulse -> busy for 8 cycles, done one cycle, G=1 L=0 E=0.
  - With SERIAL_CMP_EARLY_EXIT_EN: done after 1 BUSY cycle, same result.
- signed_mode=1, A=8'h80 (-128), B=8'h7F (+127) -> L=1.
  - Same operands with signed_mode=0 -> G=1.
- A=B=8'h3C, either mode -> E=1 after 8 BUSY cycles in both builds.
  - Assert start again in the DONE cycle with A=8'h01, B=8'h02 -> accepted back-to-back, result L=1.
- Start A=8'h10, B=8'h20; at BUSY cycle 3 assert start with A=8'hFF and change B -> ignored, final L=1.
  - Repeat with rst_n pulsed low at BUSY cycle 4 -> outputs 0 immediately, FSM IDLE, no done pulse.

Source files
------------

// File: rtl/serial_mag_comparator_if.sv
// Handshake and operand/result bundle for serial_mag_comparator.
// master = requester side, slave = comparator side.
interface serial_mag_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             G;
  logic             L;
  logic             E;

  modport master (
    output start, signed_mode, A, B,
    input  busy, done, G, L, E
  );

  modport slave (
    input  start, signed_mode, A, B,
    output busy, done, G, L, E
  );
endinterface

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator, unsigned or two's-complement per operation.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: finish on the first differing bit instead of after WIDTH cycles.
module serial_mag_comparator #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_mag_comparator_if.slave cmp
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             g_q, g_d;
  logic             l_q, l_d;
  logic             e_q, e_d;

  logic a_bit, b_bit, bit_diff, at_sign, a_wins, first_hit;
  logic gt_now, lt_now, finish;

  // NOTE: every state flop resets asynchronously and updates with <= so all
  // registers see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      g_q       <= 1'b0;
      l_q       <= 1'b0;
      e_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      signed_q  <= signed_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      g_q       <= g_d;
      l_q       <= l_d;
      e_q       <= e_d;
    end
  end

  // NOTE: every variable below is given a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    signed_d  = signed_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    g_d       = g_q;
    l_d       = l_q;
    e_d       = e_q;

    a_bit     = a_q[idx_q];
    b_bit     = b_q[idx_q];
    bit_diff  = a_bit ^ b_bit;
    // A set sign bit means a smaller two's-complement value, so the sense flips there.
    at_sign   = signed_q && (idx_q == IDX_MSB);
    a_wins    = at_sign ? ~a_bit : a_bit;
    first_hit = ~decided_q & bit_diff;
    gt_now    = first_hit ? a_wins  : gt_q;
    lt_now    = first_hit ? ~a_wins : lt_q;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    finish    = (idx_q == IDX_ZERO) || first_hit;
`else
    finish    = (idx_q == IDX_ZERO);
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cmp.start) begin
          a_d       = cmp.A;
          b_d       = cmp.B;
          signed_d  = cmp.signed_mode;
          idx_d     = IDX_MSB;
          decided_d = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          g_d       = 1'b0;
          l_d       = 1'b0;
          e_d       = 1'b0;
          state_d   = ST_BUSY;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        decided_d = decided_q | bit_diff;
        gt_d      = gt_now;
        lt_d      = lt_now;
        if (finish) begin
          g_d     = gt_now;
          l_d     = lt_now;
          e_d     = ~(decided_q | bit_diff);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmp.busy = (state_q == ST_BUSY);
  assign cmp.done = (state_q == ST_DONE);
  assign cmp.G    = g_q;
  assign cmp.L    = l_q;
  assign cmp.E    = e_q;

endmodule
